// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Row order tables are selected by TT_SWEEP_GRAY_EN in tt_row_seq.
package tt_sweep_pkg;

    localparam int unsigned ROW_W    = 3;
    localparam int unsigned TT_W     = 8;
    localparam int unsigned NUM_ROWS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_e;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [TT_W-1:0]  tt_t;

    localparam row_t ROW_ORDER_BIN [NUM_ROWS] = '{
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7
    };

    // Consecutive entries differ in exactly one bit
    localparam row_t ROW_ORDER_GRAY [NUM_ROWS] = '{
        3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4
    };

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Harness/DUT-facing signal bundle of tt_sweep_ctrl; master is the sequencer side.
interface tt_sweep_ctrl_if;
    import tt_sweep_pkg::*;

    logic start;
    logic abort;
    tt_t  expected_tt;
    row_t dut_in;
    logic dut_out;
    logic busy;
    logic done;
    logic pass;
    tt_t  observed_tt;
    tt_t  mismatch_mask;

    modport master (
        input  start, abort, expected_tt, dut_out,
        output dut_in, busy, done, pass, observed_tt, mismatch_mask
    );

    modport slave (
        output start, abort, expected_tt, dut_out,
        input  dut_in, busy, done, pass, observed_tt, mismatch_mask
    );

endinterface

// File: rtl/tt_row_seq.sv
// Row step counter and order lookup driving the DUT input row.
// TT_SWEEP_GRAY_EN selects Gray row order; otherwise binary.
module tt_row_seq
    import tt_sweep_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic advance,
    input  logic clear,
    output row_t dut_in,
    output logic last_row_c
);

    logic [ROW_W-1:0] step_q, step_d;
    row_t             row_q, row_d;

    function automatic row_t order_lut(input logic [ROW_W-1:0] step);
`ifdef TT_SWEEP_GRAY_EN
        return ROW_ORDER_GRAY[step];
`else
        return ROW_ORDER_BIN[step];
`endif
    endfunction

    always_comb begin
        step_d = step_q;
        row_d  = row_q;
        if (clear) begin
            step_d = '0;
            row_d  = '0;
        end else if (load) begin
            step_d = '0;
            row_d  = order_lut('0);
        end else if (advance) begin
            step_d = step_q + ROW_W'(1);
            row_d  = order_lut(step_q + ROW_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            row_q  <= '0;
        end else begin
            step_q <= step_d;
            row_q  <= row_d;
        end
    end

    assign dut_in     = row_q;
    assign last_row_c = (step_q == ROW_W'(NUM_ROWS - 1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 8 input rows of a 3-input logic DUT, samples its output and grades the truth table.
// Optional macro TT_SWEEP_GRAY_EN switches the row order to Gray code.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    tt_sweep_ctrl_if.master bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tt_t              exp_q, exp_d;
    tt_t              obs_q, obs_d;
    tt_t              mask_q, mask_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             seq_load, seq_adv, seq_clear;
    logic             last_row_c;
    logic             sample_c;
    row_t             row_w;
    tt_t              obs_smp;

    tt_row_seq u_row_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (seq_load),
        .advance    (seq_adv),
        .clear      (seq_clear),
        .dut_in     (row_w),
        .last_row_c (last_row_c)
    );

    // Next-state and result update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        obs_d     = obs_q;
        mask_d    = mask_q;
        pass_d    = pass_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        seq_load  = 1'b0;
        seq_adv   = 1'b0;
        seq_clear = 1'b0;
        sample_c  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
        obs_smp   = obs_q;
        obs_smp[row_w] = bus.dut_out;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    exp_d    = bus.expected_tt;
                    obs_d    = '0;
                    mask_d   = '0;
                    pass_d   = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    seq_load = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    busy_d    = 1'b0;
                    pass_d    = 1'b0;
                    seq_clear = 1'b1;
                end else if (sample_c) begin
                    cnt_d = '0;
                    obs_d = obs_smp;
                    if (last_row_c) begin
                        state_d   = REPORT;
                        done_d    = 1'b1;
                        pass_d    = (obs_smp == exp_q);
                        mask_d    = obs_smp ^ exp_q;
                        seq_clear = 1'b1;
                    end else begin
                        seq_adv = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPORT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            obs_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            obs_q   <= obs_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dut_in        = row_w;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.observed_tt   = obs_q;
    assign bus.mismatch_mask = mask_q;

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that exhaustively exercises a 3-input combinational logic circuit under test (a Cello-style NOR/NOT network) by driving all 8 input rows. It waits a programmable settle time per row, samples the circuit output, and assembles the observed 8-bit truth table. It compares that table against an expected truth-table byte and reports pass/fail with a per-row mismatch mask. It sits between a test/score harness and one DUT instance, and owns the DUT's input drive.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles each row is held before sampling; legal range 1..255
- CNT_W, $clog2(SETTLE_CYCLES+1), settle counter width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a sweep; accepted only in IDLE
- abort  in  1  cancel a sweep in progress; honoured only in RUN
- expected_tt  in  8  expected truth table; bit r = output for row r; captured on start acceptance
- dut_in  out  3  row index driven to DUT; dut_in[2] is the row MSB
- dut_out  in  1  DUT output; sampled, no synchroniser
- busy  out  1  high in RUN and REPORT
- done  out  1  one-cycle pulse at sweep completion
- pass  out  1  observed_tt == captured expected; valid from done until next start
- observed_tt  out  8  sampled truth table, indexed by row value
- mismatch_mask  out  8  observed_tt ^ captured expected

## Operation
- FSM states: IDLE, RUN, REPORT.
- IDLE -> RUN on start:
  - capture expected_tt
  - clear observed_tt, pass, mismatch_mask
  - dut_in <= order[0]
  - settle cnt <= 0, row step <= 0
- RUN, each cycle:
  - if cnt != SETTLE_CYCLES-1: cnt++
  - if cnt == SETTLE_CYCLES-1: observed_tt[dut_in] <= dut_out, cnt <= 0
    - if step < 7: step++, dut_in <= order[step+1]
    - if step == 7: go to REPORT; done <= 1; pass and mismatch_mask computed including this final sample; dut_in <= 0
- REPORT -> IDLE unconditionally after one cycle: done <= 0, busy <= 0.
- abort in RUN: next edge -> IDLE.
  - dut_in <= 0, busy <= 0, no done pulse, pass <= 0.
  - observed_tt keeps the partial result.
- abort in IDLE or REPORT: ignored.
- start in RUN or REPORT: ignored, not queued.
- abort and start together in RUN: abort wins; start is not re-examined until IDLE.
- Row order (order[]) is binary by default: 0,1,...,7.
- Reset values: all outputs 0, state IDLE, captured expected 0.
- Reset asserted mid-sweep: immediate return to reset values; no done pulse.

## Timing
- Start accepted at edge E0. dut_in = order[0] from E0.
- Sample k (k = 0..7) taken at edge E0 + (k+1)·SETTLE_CYCLES. Row k+1 is driven from that same edge.
- done is high between edges E0+8·SETTLE_CYCLES and E0+8·SETTLE_CYCLES+1. busy falls at the latter edge.
- Sweep latency: 8·SETTLE_CYCLES+1 cycles from start to IDLE. Next start is accepted at the first IDLE edge.
- SETTLE_CYCLES = 1: a new row every cycle, with no dead cycle between rows.

## Configuration
- TT_SWEEP_GRAY_EN defined: order[] = 0,1,3,2,6,7,5,4 (Gray code). Consecutive rows differ in exactly one input bit, so the DUT never sees a multi-input transition. observed_tt is still indexed by row value.
- TT_SWEEP_GRAY_EN undefined: binary order; the Gray order table is absent from the netlist.

## Structure
- Package tt_sweep_pkg:
  - state enum (IDLE, RUN, REPORT)
  - ROW_W = 3, TT_W = 8
  - ROW_ORDER_BIN and ROW_ORDER_GRAY constant arrays
- One sub-module, tt_row_seq:
  - step counter plus order lookup, producing dut_in and a last_row flag
  - inputs: load, advance, clear
  - the FSM, settle counter and result registers stay in tt_sweep_ctrl

## Test plan
- Bench NOR-network model of 0xC7, expected_tt = 0xC7, SETTLE_CYCLES = 4:
  - done pulses at edge E0+32
  - pass = 1, observed_tt = 0xC7, mismatch_mask = 0x00
- Same DUT model, expected_tt = 0xC6 -> pass = 0, mismatch_mask = 0x01.
- abort at edge E0+10 -> IDLE at E0+11, no done, dut_in = 0, observed_tt[1:0] = DUT rows 0–1, other bits 0.
- start pulsed at E0+5 during a sweep -> ignored; completion still at E0+32; start at E0+33 is accepted.
- rst_n low at E0+17 -> all outputs 0 immediately; a fresh start after release completes normally.
- TT_SWEEP_GRAY_EN defined, SETTLE_CYCLES = 1:
  - dut_in follows 0,1,3,2,6,7,5,4, Hamming distance 1 per step
  - observed_tt = 0xC7
